// File: rtl/uart_rx_fifo_ctrl.sv
// uart_rx_fifo_ctrl: RX FIFO, LSR receive bits and RX interrupts for a 16550-style UART.
// Inputs: clk, rst (async, active-low), baud_pulse, push/rx_data/pe_in/fe_in/bi_in from the RX core,
//   wls/pen/stb line format, fifo_en/fifo_clr/rx_trig FIFO control, rd/lsr_rd host strobes.
// Outputs: rd_data (show-ahead head), dr, oe/pe_o/fe_o/bi_o/fifo_err LSR bits, rx_level,
//   int_rls/int_rda/int_cti interrupt causes.
module uart_rx_fifo_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          baud_pulse,
  input  logic          push,
  input  logic [7:0]    rx_data,
  input  logic          pe_in,
  input  logic          fe_in,
  input  logic          bi_in,
  input  logic [1:0]    wls,
  input  logic          pen,
  input  logic          stb,
  input  logic          fifo_en,
  input  logic          fifo_clr,
  input  logic [1:0]    rx_trig,
  input  logic          rd,
  input  logic          lsr_rd,
  output logic [7:0]    rd_data,
  output logic          dr,
  output logic          oe,
  output logic          pe_o,
  output logic          fe_o,
  output logic          bi_o,
  output logic          fifo_err,
  output logic [AW:0]   rx_level,
  output logic          int_rls,
  output logic          int_rda,
  output logic          int_cti
);
  typedef enum logic [1:0] {T_IDLE, T_COUNT, T_EXP} t_state_e;
  logic [10:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d, err_cnt_q, err_cnt_d, trig;
  logic          oe_q, oe_d, seen_q, seen_d, fifo_en_q;
  logic [2:0]    flg_q, flg_d, flg_set;
  logic [10:0]   head, new_e;
  logic          flush, full, rd_ok, wr_ok, ovr, ow;
  logic [9:0]    cnt_q, ct;
  t_state_e      st_q;
  always_comb begin
    flush     = fifo_clr | (fifo_en ^ fifo_en_q);
    head      = mem_q[rd_ptr_q];
    new_e     = {bi_in, fe_in, pe_in, rx_data};
    dr        = level_q != '0;
    full      = fifo_en ? level_q == (AW+1)'(DEPTH) : dr;
    rd_ok     = rd & dr & ~flush;
    wr_ok     = push & ~flush & (~full | rd_ok);
    ovr       = push & ~flush & full & ~rd_ok;
    ow        = ovr & ~fifo_en;
    wr_ptr_d  = flush ? '0 : wr_ptr_q + AW'(wr_ok);
    rd_ptr_d  = flush ? '0 : rd_ptr_q + AW'(rd_ok);
    level_d   = flush ? '0 : level_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    err_cnt_d = flush ? '0 : err_cnt_q + (AW+1)'((wr_ok | ow) & |new_e[10:8])
                                       - (AW+1)'((rd_ok | ow) & |head[10:8]);
    // A head's error flags are reported once, on the first cycle it sits at the top,
    // so an LSR read clears them even while that character is still unread.
    flg_set   = (dr & ~seen_q) ? head[10:8] : 3'b0;
    flg_d     = flg_set | (flg_q & {3{~lsr_rd}});
    oe_d      = ovr | (oe_q & ~lsr_rd);
    seen_d    = dr & ~(flush | rd_ok | ow);
    trig      = rx_trig == 2'd0 ? (AW+1)'(1) : rx_trig == 2'd1 ? (AW+1)'(4) :
                rx_trig == 2'd2 ? (AW+1)'(8) : (AW+1)'(14);
    ct        = {4'd7 + {2'b0, wls} + {3'b0, pen} + {3'b0, stb}, 6'b0};
    rd_data   = dr ? head[7:0] : 8'h00;
    oe        = oe_q;
    {bi_o, fe_o, pe_o} = flg_q;
    fifo_err  = err_cnt_q != '0;
    rx_level  = level_q;
    int_rls   = oe_q | |flg_q;
    int_rda   = fifo_en ? level_q >= trig : dr;
  end
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= new_e;
    if (ow) mem_q[rd_ptr_q] <= new_e;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      err_cnt_q <= '0;
      oe_q      <= 1'b0;
      flg_q     <= 3'b0;
      seen_q    <= 1'b0;
      fifo_en_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      err_cnt_q <= err_cnt_d;
      oe_q      <= oe_d;
      flg_q     <= flg_d;
      seen_q    <= seen_d;
      fifo_en_q <= fifo_en;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= T_IDLE;
      cnt_q   <= '0;
      int_cti <= 1'b0;
    end else if (flush || level_q == '0) begin
      st_q    <= T_IDLE;
      cnt_q   <= '0;
      int_cti <= 1'b0;
    end else begin
      case (st_q)
        T_IDLE: if (fifo_en) begin
          st_q  <= T_COUNT;
          cnt_q <= '0;
        end
        T_COUNT: if (push || rd) cnt_q <= '0;
        else if (baud_pulse) begin
          if (cnt_q == ct - 10'd1) begin
            st_q    <= T_EXP;
            int_cti <= 1'b1;
          end else cnt_q <= cnt_q + 10'd1;
        end
        default: if (push || rd) begin
          st_q    <= T_COUNT;
          cnt_q   <= '0;
          int_cti <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// tb_uart_rx_fifo_ctrl: directed stimulus, queue-based reference model checked every cycle.
module tb_uart_rx_fifo_ctrl;
  logic clk = 1'b0, rst = 1'b0, baud_pulse = 1'b0, push = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic pe_in = 1'b0, fe_in = 1'b0, bi_in = 1'b0;
  logic [1:0] wls = 2'd3, rx_trig = 2'd0;
  logic pen = 1'b0, stb = 1'b0, fifo_en = 1'b1, fifo_clr = 1'b0, rd = 1'b0, lsr_rd = 1'b0;
  logic [7:0] rd_data;
  logic dr, oe, pe_o, fe_o, bi_o, fifo_err, int_rls, int_rda, int_cti;
  logic [4:0] rx_level;
  int vectors = 0, miscompares = 0;
  logic [10:0] mq[$];
  logic m_oe = 0, m_pe = 0, m_fe = 0, m_bi = 0, m_seen = 0, m_en_prev = 0, m_armed = 0;
  int m_cnt = 0;

  uart_rx_fifo_ctrl dut (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .push(push), .rx_data(rx_data),
    .pe_in(pe_in), .fe_in(fe_in), .bi_in(bi_in), .wls(wls), .pen(pen), .stb(stb),
    .fifo_en(fifo_en), .fifo_clr(fifo_clr), .rx_trig(rx_trig), .rd(rd), .lsr_rd(lsr_rd),
    .rd_data(rd_data), .dr(dr), .oe(oe), .pe_o(pe_o), .fe_o(fe_o), .bi_o(bi_o),
    .fifo_err(fifo_err), .rx_level(rx_level), .int_rls(int_rls), .int_rda(int_rda),
    .int_cti(int_cti)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] dut_vec();
    return {rd_data, dr, oe, pe_o, fe_o, bi_o, fifo_err, rx_level, int_rls, int_rda, int_cti};
  endfunction

  function automatic logic [20:0] model_vec();
    int n = mq.size();
    int errs = 0;
    int tl;
    int ct = 64 * (7 + int'(wls) + int'(pen) + int'(stb));
    foreach (mq[i]) if (mq[i][10:8] != 3'b0) errs++;
    tl = rx_trig == 0 ? 1 : rx_trig == 1 ? 4 : rx_trig == 2 ? 8 : 14;
    return {n > 0 ? mq[0][7:0] : 8'h00, n > 0, m_oe, m_pe, m_fe, m_bi, errs > 0, 5'(n),
            m_oe | m_pe | m_fe | m_bi, fifo_en ? n >= tl : n > 0, m_cnt >= ct};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      {m_oe, m_pe, m_fe, m_bi, m_seen, m_en_prev, m_armed} = '0;
      m_cnt = 0;
    end else begin
      automatic logic fl = fifo_clr || (fifo_en != m_en_prev);
      automatic int n = mq.size();
      automatic int cap = fifo_en ? 16 : 1;
      automatic int ct = 64 * (7 + int'(wls) + int'(pen) + int'(stb));
      automatic logic rd_ok = !fl && rd && n > 0;
      automatic logic ovr = !fl && push && n == cap && !rd_ok;
      automatic logic [10:0] ne = {bi_in, fe_in, pe_in, rx_data};
      if (fl || n == 0 || !fifo_en) begin m_cnt = 0; m_armed = 0; end
      else if (!m_armed) begin m_armed = 1; m_cnt = 0; end
      else if (push || rd) m_cnt = 0;
      else if (baud_pulse && m_cnt < ct) m_cnt++;
      if (lsr_rd) {m_oe, m_pe, m_fe, m_bi} = '0;
      if (n > 0 && !m_seen) begin
        m_pe |= mq[0][8];
        m_fe |= mq[0][9];
        m_bi |= mq[0][10];
      end
      if (ovr) m_oe = 1;
      m_seen = n > 0 && !(fl || rd_ok || (ovr && !fifo_en));
      if (fl) mq.delete();
      else if (ovr && !fifo_en) mq[0] = ne;
      else if (!ovr) begin
        if (rd_ok) void'(mq.pop_front());
        if (push) mq.push_back(ne);
      end
      m_en_prev = fifo_en;
    end
  end

  always @(negedge clk) begin
    automatic logic [20:0] g = dut_vec();
    automatic logic [20:0] e = model_vec();
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, g, e);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
    push = 0; rd = 0; lsr_rd = 0; fifo_clr = 0;
    {pe_in, fe_in, bi_in} = 3'b0;
  endtask

  task automatic do_push(input logic [7:0] d, input logic [2:0] f = 3'b0);
    push = 1; rx_data = d; {bi_in, fe_in, pe_in} = f;
    clk1();
  endtask

  task automatic do_rd();
    rd = 1;
    clk1();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_level", 32'(rx_level), 0);
    chk("reset_outs", 32'(dut_vec()), 0);
    rst = 1;
    clk1(); clk1();
    // 1: in-order show-ahead reads
    do_push(8'h55); do_push(8'hAA); do_push(8'h0F);
    chk("t1_head", 32'(rd_data), 32'h55);
    chk("t1_level", 32'(rx_level), 3);
    do_rd(); chk("t1_rd1", 32'(rd_data), 32'hAA);
    do_rd(); chk("t1_rd2", 32'(rd_data), 32'h0F);
    do_rd(); chk("t1_dr0", {31'd0, dr}, 0);
    chk("t1_empty_data", 32'(rd_data), 0);
    push = 1; rd = 1; rx_data = 8'h77; clk1();
    chk("t1_pushrd_empty", {23'd0, rd_data, dr}, {23'd0, 8'h77, 1'b1});
    do_rd();
    // 2: overrun in FIFO mode
    for (int i = 1; i <= 16; i++) do_push(8'(i));
    chk("t2_full_oe0", {27'd0, oe, rx_level}, {27'd0, 1'b0, 5'd16});
    do_push(8'hEE);
    chk("t2_oe", {31'd0, oe}, 1);
    chk("t2_head", 32'(rd_data), 1);
    lsr_rd = 1; clk1();
    chk("t2_oe_clr", {31'd0, oe}, 0);
    push = 1; rd = 1; rx_data = 8'hDD; clk1();
    chk("t2_pushrd_full", {19'd0, oe, rx_level, rd_data}, {19'd0, 1'b0, 5'd16, 8'h02});
    fifo_clr = 1; clk1();
    // 3: framing error reporting
    do_push(8'h41, 3'b010); do_push(8'h42);
    chk("t3_fe", {30'd0, fe_o, fifo_err}, 3);
    lsr_rd = 1; clk1();
    do_rd();
    chk("t3_after", {22'd0, fe_o, fifo_err, rd_data}, {22'd0, 2'b00, 8'h42});
    do_rd();
    // 4: character timeout, trigger 4, 10-bit frame
    rx_trig = 2'd1; wls = 2'd3; pen = 0; stb = 0;
    do_push(8'h01); do_push(8'h02); do_push(8'h03);
    chk("t4_rda0", {31'd0, int_rda}, 0);
    for (int i = 0; i < 639; i++) begin
      baud_pulse = 1; clk1(); baud_pulse = 0; clk1();
    end
    chk("t4_cti_639", {31'd0, int_cti}, 0);
    baud_pulse = 1; clk1(); baud_pulse = 0;
    chk("t4_cti_640", {31'd0, int_cti}, 1);
    do_rd();
    chk("t4_cti_rd", {31'd0, int_cti}, 0);
    do_push(8'h04);
    chk("t4_rda_l3", {31'd0, int_rda}, 0);
    do_push(8'h05);
    chk("t4_rda_l4", {31'd0, int_rda}, 1);
    fifo_clr = 1; clk1();
    // 5: holding-register mode overwrite
    fifo_en = 0; clk1(); clk1();
    do_push(8'h11); do_push(8'h22);
    chk("t5_hold", {19'd0, oe, rx_level, rd_data}, {19'd0, 1'b1, 5'd1, 8'h22});
    fifo_en = 1; clk1(); clk1();
    // 6: flush beats push, then async reset
    for (int i = 0; i < 5; i++) do_push(8'(8'h30 + i));
    chk("t6_level5", 32'(rx_level), 5);
    fifo_clr = 1; push = 1; rx_data = 8'h99; clk1();
    chk("t6_flush", {25'd0, oe, dr, rx_level}, {25'd0, 1'b1, 1'b0, 5'd0});
    do_push(8'hA1); do_push(8'hA2, 3'b001); do_push(8'hA3);
    @(posedge clk);
    #2 rst = 0;
    #1 chk("t6_async_rst", 32'(dut_vec()), 0);
    @(posedge clk);
    #1 rst = 1;
    repeat (3) clk1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
